// File: rtl/alu_cmd_sequencer.sv
// Command front end for the 8-bit combinational ALU: folds (op, operand) commands into an accumulator.
// Optional sticky carry/borrow flag on rsp_ovf is built only when ALU_SEQ_OVF_EN is defined.
module alu_cmd_sequencer #(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_operand,
   input  logic             cmd_last,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_ovf
);

   typedef enum logic [1:0] {
      ACCEPT = 2'd0,
      EXEC   = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] operand_q, operand_d;
   logic [1:0]       op_q, op_d;
   logic             last_q, last_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ACCEPT;
         acc_q     <= ACC_INIT;
         operand_q <= '0;
         op_q      <= '0;
         last_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         operand_q <= operand_d;
         op_q      <= op_d;
         last_q    <= last_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      operand_d = operand_q;
      op_d      = op_q;
      last_d    = last_q;
      case (state_q)
         ACCEPT: begin
            if (cmd_valid) begin
               op_d      = cmd_op;
               operand_d = cmd_operand;
               last_d    = cmd_last;
               state_d   = EXEC;
            end
         end
         EXEC: begin
            acc_d   = alu_result;
            state_d = last_q ? RESP : ACCEPT;
         end
         RESP: begin
            if (rsp_ready) begin
               acc_d   = ACC_INIT;
               state_d = ACCEPT;
            end
         end
         default: state_d = ACCEPT;
      endcase
   end

   // Handshake outputs decode from state only; ALU drive comes straight from registers.
   assign cmd_ready = (state_q == ACCEPT);
   assign rsp_valid = (state_q == RESP);
   assign rsp_data  = acc_q;
   assign alu_a     = acc_q;
   assign alu_b     = operand_q;
   assign alu_op    = op_q;

`ifdef ALU_SEQ_OVF_EN
   logic ovf_q, ovf_d;

   // acc + operand overflows exactly when operand exceeds the headroom ~acc.
   always_comb begin
      ovf_d = ovf_q;
      case (state_q)
         EXEC: begin
            if ((op_q == 2'b00) && (operand_q > ~acc_q))
               ovf_d = 1'b1;
            else if ((op_q == 2'b01) && (operand_q > acc_q))
               ovf_d = 1'b1;
         end
         RESP: begin
            if (rsp_ready)
               ovf_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ovf_q <= 1'b0;
      else
         ovf_q <= ovf_d;
   end

   assign rsp_ovf = ovf_q & rsp_valid;
`else
   assign rsp_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer, with a behavioural model of the external ALU.
module tb_alu_cmd_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [7:0] cmd_operand;
   logic       cmd_last;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [1:0] alu_op;
   logic [7:0] alu_result;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic       rsp_ovf;

   int testsRun  = 0;
   int testsFail = 0;

`ifdef ALU_SEQ_OVF_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   alu_cmd_sequencer #(.WIDTH(8), .ACC_INIT(8'h00)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_operand (cmd_operand),
      .cmd_last    (cmd_last),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_op      (alu_op),
      .alu_result  (alu_result),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .rsp_ovf     (rsp_ovf)
   );

   always #5 clk = ~clk;

   // External ALU: 00 ADD, 01 SUB, 10 AND, 11 OR
   always_comb begin
      alu_result = 8'h00;
      case (alu_op)
         2'b00: alu_result = alu_a + alu_b;
         2'b01: alu_result = alu_a - alu_b;
         2'b10: alu_result = alu_a & alu_b;
         2'b11: alu_result = alu_a | alu_b;
         default: alu_result = 8'h00;
      endcase
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Presents one command and returns #1 after the edge that accepted it (DUT then in EXEC).
   task automatic applyStimulus(input logic [1:0] op, input logic [7:0] operand, input logic last);
      int waitCycles = 0;
      cmd_valid   = 1'b1;
      cmd_op      = op;
      cmd_operand = operand;
      cmd_last    = last;
      while (!cmd_ready && waitCycles < 20) begin
         @(posedge clk); #1;
         waitCycles++;
      end
      if (!cmd_ready)
         checkOutput("cmdAcceptTimeout", 32'(cmd_ready), 32'd1);
      @(posedge clk); #1;
      cmd_valid   = 1'b0;
      cmd_op      = 2'b11;
      cmd_operand = 8'hEE;
      cmd_last    = 1'b0;
   endtask

   task automatic getResponse(input string tag, input logic [7:0] expData, input logic expOvf);
      int waitCycles = 0;
      while (!rsp_valid && waitCycles < 20) begin
         @(posedge clk); #1;
         waitCycles++;
      end
      checkOutput({tag, "_valid"}, 32'(rsp_valid), 32'd1);
      checkOutput({tag, "_data"}, 32'(rsp_data), 32'(expData));
      checkOutput({tag, "_ovf"}, 32'(rsp_ovf), 32'(expOvf));
      checkOutput({tag, "_cmdReadyLow"}, 32'(cmd_ready), 32'd0);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      checkOutput({tag, "_validDrop"}, 32'(rsp_valid), 32'd0);
      checkOutput({tag, "_cmdReadyBack"}, 32'(cmd_ready), 32'd1);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_cmdReady"}, 32'(cmd_ready), 32'd1);
      checkOutput({tag, "_rspValid"}, 32'(rsp_valid), 32'd0);
      checkOutput({tag, "_rspData"}, 32'(rsp_data), 32'h00);
      checkOutput({tag, "_aluA"}, 32'(alu_a), 32'h00);
      checkOutput({tag, "_aluB"}, 32'(alu_b), 32'h00);
      checkOutput({tag, "_aluOp"}, 32'(alu_op), 32'd0);
      checkOutput({tag, "_rspOvf"}, 32'(rsp_ovf), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Continuous-stream vectors: op, operand, and accumulator seen on alu_a during that EXEC.
   logic [1:0] streamOp  [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
   logic [7:0] streamOpd [4] = '{8'h10, 8'h04, 8'h81, 8'hF0};
   logic [7:0] streamAcc [4] = '{8'h00, 8'h10, 8'h0C, 8'h8D};

   initial begin
      int accepted;
      logic sawReady;

      rst_n       = 1'b0;
      cmd_valid   = 1'b0;
      cmd_op      = 2'b00;
      cmd_operand = 8'h00;
      cmd_last    = 1'b0;
      rsp_ready   = 1'b0;
      #12;
      checkResetOutputs("por");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic ADD/ADD/SUB sequence
      applyStimulus(2'b00, 8'h05, 1'b0);
      applyStimulus(2'b00, 8'h03, 1'b0);
      applyStimulus(2'b01, 8'h02, 1'b1);
      getResponse("addSub", 8'h06, 1'b0);

      // AND masking, then a fresh single-command sequence
      applyStimulus(2'b00, 8'hF0, 1'b0);
      applyStimulus(2'b10, 8'h3C, 1'b1);
      getResponse("andMask", 8'h30, 1'b0);
      applyStimulus(2'b11, 8'hA5, 1'b1);
      getResponse("orFresh", 8'hA5, 1'b0);

      // Wraparound with carry and borrow
      applyStimulus(2'b00, 8'hFF, 1'b0);
      applyStimulus(2'b00, 8'h02, 1'b1);
      getResponse("ovfAdd", 8'h01, OVF_ON);
      applyStimulus(2'b01, 8'h01, 1'b1);
      getResponse("ovfSub", 8'hFF, OVF_ON);

      // Backpressure on the response while commands are offered
      applyStimulus(2'b00, 8'h11, 1'b1);
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cmd_op      = 2'(i);
         cmd_operand = 8'(8'h50 + i);
         cmd_last    = 1'(i);
         checkOutput("holdValid", 32'(rsp_valid), 32'd1);
         checkOutput("holdData", 32'(rsp_data), 32'h11);
         checkOutput("holdCmdReady", 32'(cmd_ready), 32'd0);
         @(posedge clk); #1;
      end
      cmd_op      = 2'b00;
      cmd_operand = 8'h22;
      cmd_last    = 1'b1;
      rsp_ready   = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      checkOutput("holdRelease_valid", 32'(rsp_valid), 32'd0);
      checkOutput("holdRelease_cmdReady", 32'(cmd_ready), 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      checkOutput("nextAccept_cmdReady", 32'(cmd_ready), 32'd0);
      checkOutput("nextAccept_aluA", 32'(alu_a), 32'h00);
      checkOutput("nextAccept_aluB", 32'(alu_b), 32'h22);
      getResponse("nextSeq", 8'h22, 1'b0);

      // Continuous cmd_valid stream of four commands
      accepted    = 0;
      cmd_valid   = 1'b1;
      cmd_op      = streamOp[0];
      cmd_operand = streamOpd[0];
      cmd_last    = 1'b0;
      for (int c = 0; c < 8; c++) begin
         sawReady = cmd_ready;
         checkOutput($sformatf("stream_ready%0d", c), 32'(sawReady), 32'((c % 2) == 0));
         if (!sawReady && accepted > 0) begin
            checkOutput($sformatf("stream_aluA%0d", c), 32'(alu_a), 32'(streamAcc[accepted-1]));
            checkOutput($sformatf("stream_aluB%0d", c), 32'(alu_b), 32'(streamOpd[accepted-1]));
            checkOutput($sformatf("stream_aluOp%0d", c), 32'(alu_op), 32'(streamOp[accepted-1]));
         end
         @(posedge clk); #1;
         if (sawReady && cmd_valid) begin
            accepted++;
            if (accepted < 4) begin
               cmd_op      = streamOp[accepted];
               cmd_operand = streamOpd[accepted];
               cmd_last    = (accepted == 3);
            end else begin
               cmd_valid = 1'b0;
            end
         end
      end
      cmd_valid = 1'b0;
      checkOutput("stream_accepted", 32'(accepted), 32'd4);
      getResponse("stream", 8'h80, 1'b0);

      // Asynchronous reset during EXEC
      applyStimulus(2'b11, 8'h33, 1'b0);
      checkOutput("preRstExec_aluOp", 32'(alu_op), 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      checkResetOutputs("rstExec");
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Asynchronous reset during RESP
      applyStimulus(2'b00, 8'h44, 1'b1);
      @(posedge clk); #1;
      checkOutput("preRstResp_valid", 32'(rsp_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkResetOutputs("rstResp");
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;

      applyStimulus(2'b00, 8'h07, 1'b1);
      getResponse("postRst", 8'h07, 1'b0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
      $finish;
   end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Sequential command front end that initiates operations on the team's 8-bit combinational ALU (op codes 00 ADD, 01 SUB, 10 AND, 11 OR). It accepts a stream of (op, operand) commands over a valid/ready interface and folds them into an accumulator by driving the ALU's a/b/op_code inputs and capturing its result. It returns the final accumulator on a valid/ready response interface when the last command of a sequence retires. It sits between a command source (host/testbench/microcontroller) and an external ALU instance.

## Interface
- WIDTH, 8, datapath width; must match the ALU width
- ACC_INIT, 0, accumulator value at reset and at the start of every sequence
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer accepts a command this cycle
- cmd_op  input  2  ALU op code for this command
- cmd_operand  input  WIDTH  operand b
- cmd_last  input  1  final command of the sequence
- alu_a  output  WIDTH  to ALU a; always equals the accumulator register
- alu_b  output  WIDTH  to ALU b; registered operand
- alu_op  output  2  to ALU op_code; registered op
- alu_result  input  WIDTH  from ALU result (combinational)
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts the response
- rsp_data  output  WIDTH  final accumulator value
- rsp_ovf  output  1  sticky carry/borrow flag (see Configuration)

## Operation
- States: ACCEPT, EXEC, RESP. Reset state is ACCEPT.
- ACCEPT:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch cmd_op into the op register, cmd_operand into the operand register, and cmd_last into the last flag.
  - Go to EXEC. No handshake means stay in ACCEPT.
- EXEC:
  - cmd_ready=0.
  - acc <= alu_result.
  - If last flag is set, go to RESP; otherwise go to ACCEPT.
- RESP:
  - rsp_valid=1 and rsp_data=acc, both held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: acc <= ACC_INIT, rsp_ovf flag clears, go to ACCEPT.
  - cmd_ready=0 throughout RESP.
- Arithmetic is the ALU's: modulo 2^WIDTH, no saturation. The sequencer never computes the result itself.
- cmd_op/cmd_operand/cmd_last are sampled only on the accepting edge. Later changes are ignored.
- Reset mid-operation: acc=ACC_INIT, and the op and operand registers clear to 0. Any command held in EXEC is discarded, as is any response pending in RESP.
- Outputs after reset:
  - cmd_ready=1
  - rsp_valid=0
  - rsp_data=ACC_INIT
  - alu_a=ACC_INIT
  - alu_b=0
  - alu_op=00
  - rsp_ovf=0
- rsp_ready is ignored outside RESP. cmd_valid is ignored outside ACCEPT.

## Timing
- Throughput: one command per 2 cycles (ACCEPT, EXEC). Back-to-back cmd_valid sees cmd_ready toggle 1,0,1,0.
- Latency: cmd_last accepted at edge k, acc updated at edge k+1, rsp_valid=1 from edge k+1.
- The ALU path (alu_a/alu_b/alu_op to alu_result) is a single-cycle combinational path closed in EXEC. alu_* outputs come straight from registers.
- The earliest next command acceptance is the edge after the rsp handshake edge.
- cmd_ready and rsp_valid are decoded from state only. There is no combinational path from cmd_valid or rsp_ready.

## Configuration
- Macro ALU_SEQ_OVF_EN.
- Defined:
  - In EXEC, for op 00 set the sticky flag if acc+operand exceeds 2^WIDTH-1.
  - For op 01 set the flag if operand>acc (borrow).
  - The flag is computed internally from the registered operands. AND/OR never set it.
  - rsp_ovf presents the flag while rsp_valid. The flag clears on the rsp handshake and on reset.
- Undefined: no flag logic; rsp_ovf is tied to 0.

## Test plan
- Commands ADD 0x05, ADD 0x03, SUB 0x02(last), rsp_ready=1 -> rsp_data=0x06 and rsp_ovf=0; rsp_valid high exactly 1 cycle.
- Commands ADD 0xF0, AND 0x3C(last) -> rsp_data=0x30. A single OR 0xA5(last) as the next sequence -> rsp_data=0xA5, proving acc reset to ACC_INIT.
- Commands ADD 0xFF, ADD 0x02(last) -> rsp_data=0x01, rsp_ovf=1 with ALU_SEQ_OVF_EN and 0 without. SUB 0x01(last) from a fresh sequence -> 0xFF, rsp_ovf=1 (enabled).
- In RESP, hold rsp_ready=0 for 5 cycles while cmd_valid=1 with changing data -> rsp_valid/rsp_data are stable and cmd_ready=0 throughout. Raise rsp_ready -> handshake completes, and the next command is accepted the following cycle.
- cmd_valid held continuously with 4 commands -> cmd_ready pattern is 1,0,1,0 and exactly 4 commands are accepted. Verify alu_a/alu_b/alu_op match acc/operand/op in each EXEC cycle.
- Assert rst_n low asynchronously mid-EXEC and again mid-RESP -> outputs take reset values immediately. After release, ADD 0x07(last) -> rsp_data=0x07.
